// File: rtl/bridge_pkg.sv
// ---------------------------------------------------------------------------
// bridge_pkg
// Shared definitions for the sram-to-AXI bridge:
//   - bridgeState_e : FSM state encoding
//   - OWNER_*       : which core port owns the in-flight transaction
//   - SIZE_WORD     : the fixed size used for instruction fetches
//   - ID_*          : AXI transaction IDs
//   - axiSize()     : widens the 2-bit sram size into a 3-bit AXI size
// Optional feature macro used by the bridge: BRIDGE_TIMEOUT_EN
// ---------------------------------------------------------------------------
package bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4
    } bridgeState_e;

    localparam logic       OWNER_INST      = 1'b0;
    localparam logic       OWNER_DATA      = 1'b1;

    localparam logic [1:0] SIZE_WORD       = 2'd2;

    localparam logic [3:0] ID_INST         = 4'd0;
    localparam logic [3:0] ID_DATA_DEFAULT = 4'd1;

    localparam int         WAIT_CNT_W      = 16;

    function automatic logic [2:0] axiSize(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/axi_req_latch.sv
// ---------------------------------------------------------------------------
// axi_req_latch
// Captures the fields of the granted sram request so that the AXI address
// and write channels can present them stably for the whole transaction.
// Ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   load_i          : capture the *_i fields this cycle (request granted)
//   owner_i/_o      : OWNER_INST or OWNER_DATA
//   wr_i/_o         : 1 = write
//   size_i/_o       : sram size code (0 byte, 1 half, 2 word)
//   addr_i/_o       : physical address
//   wstrb_i/_o      : write byte enables
//   wdata_i/_o      : write data
// ---------------------------------------------------------------------------
module axi_req_latch
    import bridge_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        owner_i,
    input  logic        wr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  wstrb_i,
    input  logic [31:0] wdata_i,
    output logic        owner_o,
    output logic        wr_o,
    output logic [1:0]  size_o,
    output logic [31:0] addr_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o
);

    logic        owner_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q <= OWNER_INST;
            wr_q    <= 1'b0;
            size_q  <= 2'd0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
        end else if (load_i) begin
            owner_q <= owner_i;
            wr_q    <= wr_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wstrb_q <= wstrb_i;
            wdata_q <= wdata_i;
        end
    end

    assign owner_o = owner_q;
    assign wr_o    = wr_q;
    assign size_o  = size_q;
    assign addr_o  = addr_q;
    assign wstrb_o = wstrb_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// sram_axi_bridge
// Arbitrates the CPU core's inst and data sram-like ports onto one AXI3
// master. Single beat, one transaction outstanding, data port has fixed
// priority over the inst port.
// Ports:
//   clk, resetn                 : clock, asynchronous active-low reset
//   inst_* (req/addr/addr_ok/data_ok/rdata) : instruction fetch port
//   data_* (req/wr/size/wstrb/addr/wdata/addr_ok/data_ok/rdata) : data port
//   ar*, r*, aw*, w*, b*        : AXI3 master channels
//   err                         : sticky wait-timeout flag
// Parameters:
//   TIMEOUT_CYC : cycles in one wait state before err is raised
//   DATA_ID     : AXI ID for data-port transactions (inst uses ID_INST)
// Optional feature: define BRIDGE_TIMEOUT_EN to build the wait counter;
// without it err is tied low.
// ---------------------------------------------------------------------------
module sram_axi_bridge
    import bridge_pkg::*;
#(
    parameter int         TIMEOUT_CYC = 1024,
    parameter logic [3:0] DATA_ID     = ID_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready,
    output logic        err
);

    bridgeState_e state_q;
    logic         arvalid_q;
    logic         rready_q;
    logic         awvalid_q;
    logic         wvalid_q;
    logic         bready_q;
    logic         awDone_q;
    logic         wDone_q;
    logic         instDataOk_q;
    logic         dataDataOk_q;
    logic [31:0]  instRdata_q;
    logic [31:0]  dataRdata_q;

    logic         canAccept;
    logic         grantData;
    logic         grantInst;
    logic         reqLoad;
    logic         awDoneNow;
    logic         wDoneNow;

    logic         latOwner;
    logic         latWr;
    logic [1:0]   latSize;
    logic [31:0]  latAddr;
    logic [3:0]   latWstrb;
    logic [31:0]  latWdata;

    // Acceptance is blocked while a data_ok pulse is out, so a new request
    // never shares a cycle with the completion of the previous one.
    assign canAccept    = (state_q == ST_IDLE) && !instDataOk_q && !dataDataOk_q;
    assign grantData    = canAccept && data_req;
    assign grantInst    = canAccept && !data_req && inst_req;
    assign reqLoad      = grantData || grantInst;

    assign data_addr_ok = grantData;
    assign inst_addr_ok = grantInst;

    axi_req_latch u_req_latch (
        .clk     (clk),
        .rst_n   (resetn),
        .load_i  (reqLoad),
        .owner_i (grantData ? OWNER_DATA : OWNER_INST),
        .wr_i    (grantData && data_wr),
        .size_i  (grantData ? data_size : SIZE_WORD),
        .addr_i  (grantData ? data_addr : inst_addr),
        .wstrb_i (data_wstrb),
        .wdata_i (data_wdata),
        .owner_o (latOwner),
        .wr_o    (latWr),
        .size_o  (latSize),
        .addr_o  (latAddr),
        .wstrb_o (latWstrb),
        .wdata_o (latWdata)
    );

    // A channel counts as done if it finished earlier or handshakes now.
    assign awDoneNow = awDone_q || (awvalid_q && awready);
    assign wDoneNow  = wDone_q  || (wvalid_q  && wready);

    // Transaction FSM; all AXI valids/readies and data_ok pulses are
    // registered here so they change only on clock edges.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            awDone_q     <= 1'b0;
            wDone_q      <= 1'b0;
            instDataOk_q <= 1'b0;
            dataDataOk_q <= 1'b0;
            instRdata_q  <= 32'd0;
            dataRdata_q  <= 32'd0;
        end else begin
            instDataOk_q <= 1'b0;
            dataDataOk_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (reqLoad) begin
                        if (grantData && data_wr) begin
                            state_q   <= ST_WR_REQ;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            awDone_q  <= 1'b0;
                            wDone_q   <= 1'b0;
                        end else begin
                            state_q   <= ST_RD_ADDR;
                            arvalid_q <= 1'b1;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= ST_IDLE;
                        if (latOwner == OWNER_DATA) begin
                            dataRdata_q  <= rdata;
                            dataDataOk_q <= 1'b1;
                        end else begin
                            instRdata_q  <= rdata;
                            instDataOk_q <= 1'b1;
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (awDoneNow && wDoneNow) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b0;
                        awDone_q  <= 1'b0;
                        wDone_q   <= 1'b0;
                        bready_q  <= 1'b1;
                        state_q   <= ST_WR_RESP;
                    end else begin
                        if (awvalid_q && awready) begin
                            awvalid_q <= 1'b0;
                            awDone_q  <= 1'b1;
                        end
                        if (wvalid_q && wready) begin
                            wvalid_q <= 1'b0;
                            wDone_q  <= 1'b1;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid) begin
                        bready_q     <= 1'b0;
                        dataDataOk_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign arid         = (latOwner == OWNER_DATA) ? DATA_ID : ID_INST;
    assign araddr       = latAddr;
    assign arsize       = axiSize(latSize);
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign awid         = (latOwner == OWNER_DATA) ? DATA_ID : ID_INST;
    assign awaddr       = latAddr;
    assign awsize       = axiSize(latSize);
    assign awvalid      = awvalid_q;
    assign wdata        = latWdata;
    assign wstrb        = latWstrb;
    assign wlast        = wvalid_q;
    assign wvalid       = wvalid_q;
    assign bready       = bready_q;
    assign inst_data_ok = instDataOk_q;
    assign inst_rdata   = instRdata_q;
    assign data_data_ok = dataDataOk_q;
    assign data_rdata   = dataRdata_q;

    // Response IDs/status and the latched write flag carry no information
    // the bridge acts on; the FSM already knows the direction.
    logic unusedSignals;
    assign unusedSignals = ^{rid, rresp, rlast, bid, bresp, latWr};

`ifdef BRIDGE_TIMEOUT_EN
    bridgeState_e            prevState_q;
    logic [WAIT_CNT_W-1:0]   waitCnt_q;
    logic [WAIT_CNT_W-1:0]   waitCnt_d;
    logic                    err_q;

    // waitCnt_d is the number of cycles spent so far in the current
    // non-IDLE state, restarting whenever the state changes; it saturates
    // rather than wrapping so a long stall cannot re-arm a stale count.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (state_q == ST_IDLE) begin
            waitCnt_d = '0;
        end else if (state_q != prevState_q) begin
            waitCnt_d = WAIT_CNT_W'(1);
        end else if (waitCnt_q != '1) begin
            waitCnt_d = waitCnt_q + WAIT_CNT_W'(1);
        end
    end

    // err is sticky until reset; the FSM itself keeps waiting.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prevState_q <= ST_IDLE;
            waitCnt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            prevState_q <= state_q;
            waitCnt_q   <= waitCnt_d;
            if (waitCnt_d == WAIT_CNT_W'(TIMEOUT_CYC)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    localparam int unusedTimeoutCyc = TIMEOUT_CYC;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_axi_bridge.sv
// ---------------------------------------------------------------------------
// tb_sram_axi_bridge
// Directed bench for sram_axi_bridge. The AXI slave is driven by hand cycle
// by cycle; inputs change and outputs are sampled just after the falling
// clock edge. Define BRIDGE_TIMEOUT_EN to also exercise the timeout flag
// (the DUT is built with TIMEOUT_CYC = 8).
// ---------------------------------------------------------------------------
module tb_sram_axi_bridge;

    logic        clk;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic        err;

    int testsRun;
    int testsFailed;

    logic [31:0] b2bAddr [3];
    logic [31:0] b2bData [3];

    sram_axi_bridge #(
        .TIMEOUT_CYC (8),
        .DATA_ID     (4'd1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .arid         (arid),
        .araddr       (araddr),
        .arsize       (arsize),
        .arvalid      (arvalid),
        .arready      (arready),
        .rid          (rid),
        .rdata        (rdata),
        .rresp        (rresp),
        .rlast        (rlast),
        .rvalid       (rvalid),
        .rready       (rready),
        .awid         (awid),
        .awaddr       (awaddr),
        .awsize       (awsize),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wlast        (wlast),
        .wvalid       (wvalid),
        .wready       (wready),
        .bid          (bid),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .err          (err)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next falling edge, where outputs are stable.
    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    // Drives a data read in the current (accepting) cycle and follows it to
    // completion with a zero-wait slave; leaves the bench one cycle after
    // data_ok, which is again an accepting cycle.
    task automatic applyStimulus(input string tag, input logic [31:0] addr,
                                 input logic [31:0] value);
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = addr;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = value;
        #1;
        checkOutput({tag, "_addr_ok"}, {31'd0, data_addr_ok}, 32'd1);
        stepCycle();
        data_req = 1'b0;
        checkOutput({tag, "_araddr"}, araddr, addr);
        stepCycle();
        stepCycle();
        checkOutput({tag, "_data_ok"}, {31'd0, data_data_ok}, 32'd1);
        checkOutput({tag, "_rdata"}, data_rdata, value);
        stepCycle();
        checkOutput({tag, "_data_ok_low"}, {31'd0, data_data_ok}, 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        resetn      = 1'b0;
        inst_req    = 1'b0;
        inst_addr   = 32'd0;
        data_req    = 1'b0;
        data_wr     = 1'b0;
        data_size   = 2'd0;
        data_wstrb  = 4'd0;
        data_addr   = 32'd0;
        data_wdata  = 32'd0;
        arready     = 1'b0;
        rid         = 4'd0;
        rdata       = 32'd0;
        rresp       = 2'd0;
        rlast       = 1'b1;
        rvalid      = 1'b0;
        awready     = 1'b0;
        wready      = 1'b0;
        bid         = 4'd0;
        bresp       = 2'd0;
        bvalid      = 1'b0;

        // Reset state
        stepCycle();
        stepCycle();
        checkOutput("rst_arvalid", {31'd0, arvalid}, 32'd0);
        checkOutput("rst_awvalid", {31'd0, awvalid}, 32'd0);
        checkOutput("rst_wvalid", {31'd0, wvalid}, 32'd0);
        checkOutput("rst_rready", {31'd0, rready}, 32'd0);
        checkOutput("rst_bready", {31'd0, bready}, 32'd0);
        checkOutput("rst_inst_data_ok", {31'd0, inst_data_ok}, 32'd0);
        checkOutput("rst_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        checkOutput("rst_inst_rdata", inst_rdata, 32'd0);
        checkOutput("rst_data_rdata", data_rdata, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        resetn = 1'b1;

        // 1: inst read with a zero-wait slave
        stepCycle();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        arready   = 1'b1;
        rvalid    = 1'b1;
        rdata     = 32'h3C1D_8000;
        #1;
        checkOutput("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        checkOutput("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
        stepCycle();
        inst_req = 1'b0;
        #1;
        checkOutput("t1_arvalid", {31'd0, arvalid}, 32'd1);
        checkOutput("t1_araddr", araddr, 32'hBFC0_0000);
        checkOutput("t1_arid", {28'd0, arid}, 32'd0);
        checkOutput("t1_arsize", {29'd0, arsize}, 32'd2);
        checkOutput("t1_addr_ok_busy", {31'd0, inst_addr_ok}, 32'd0);
        stepCycle();
        checkOutput("t1_rready", {31'd0, rready}, 32'd1);
        checkOutput("t1_arvalid_low", {31'd0, arvalid}, 32'd0);
        checkOutput("t1_early_data_ok", {31'd0, inst_data_ok}, 32'd0);
        stepCycle();
        checkOutput("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        checkOutput("t1_inst_rdata", inst_rdata, 32'h3C1D_8000);
        checkOutput("t1_data_data_ok", {31'd0, data_data_ok}, 32'd0);
        stepCycle();
        checkOutput("t1_inst_data_ok_low", {31'd0, inst_data_ok}, 32'd0);

        // 2: simultaneous requests, data wins, inst waits
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0004;
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd2;
        data_addr = 32'h8000_1000;
        rdata     = 32'h1122_3344;
        #1;
        checkOutput("t2_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        checkOutput("t2_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
        stepCycle();
        data_req = 1'b0;
        #1;
        checkOutput("t2_arid", {28'd0, arid}, 32'd1);
        checkOutput("t2_araddr", araddr, 32'h8000_1000);
        checkOutput("t2_inst_wait", {31'd0, inst_addr_ok}, 32'd0);
        stepCycle();
        stepCycle();
        checkOutput("t2_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        checkOutput("t2_data_rdata", data_rdata, 32'h1122_3344);
        checkOutput("t2_no_accept_on_ok", {31'd0, inst_addr_ok}, 32'd0);
        stepCycle();
        checkOutput("t2_inst_granted", {31'd0, inst_addr_ok}, 32'd1);
        rdata = 32'h5566_7788;
        stepCycle();
        inst_req = 1'b0;
        checkOutput("t2_inst_arid", {28'd0, arid}, 32'd0);
        checkOutput("t2_inst_araddr", araddr, 32'hBFC0_0004);
        stepCycle();
        stepCycle();
        checkOutput("t2_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
        checkOutput("t2_inst_rdata", inst_rdata, 32'h5566_7788);
        checkOutput("t2_data_rdata_kept", data_rdata, 32'h1122_3344);
        stepCycle();

        // 3: half-word write, awready delayed, wready immediate
        awready    = 1'b0;
        wready     = 1'b1;
        bvalid     = 1'b0;
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_size  = 2'd1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h8000_2000;
        data_wdata = 32'h1234_5678;
        #1;
        checkOutput("t3_data_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        stepCycle();
        data_req = 1'b0;
        data_wr  = 1'b0;
        checkOutput("t3_awvalid_c1", {31'd0, awvalid}, 32'd1);
        checkOutput("t3_wvalid_c1", {31'd0, wvalid}, 32'd1);
        checkOutput("t3_wlast", {31'd0, wlast}, 32'd1);
        checkOutput("t3_awsize", {29'd0, awsize}, 32'd1);
        checkOutput("t3_awid", {28'd0, awid}, 32'd1);
        checkOutput("t3_awaddr", awaddr, 32'h8000_2000);
        checkOutput("t3_wdata", wdata, 32'h1234_5678);
        checkOutput("t3_wstrb", {28'd0, wstrb}, 32'h3);
        stepCycle();
        checkOutput("t3_wvalid_c2", {31'd0, wvalid}, 32'd0);
        checkOutput("t3_awvalid_c2", {31'd0, awvalid}, 32'd1);
        stepCycle();
        checkOutput("t3_awvalid_c3", {31'd0, awvalid}, 32'd1);
        stepCycle();
        checkOutput("t3_awvalid_c4", {31'd0, awvalid}, 32'd1);
        checkOutput("t3_bready_early", {31'd0, bready}, 32'd0);
        awready = 1'b1;
        stepCycle();
        awready = 1'b0;
        checkOutput("t3_awvalid_c5", {31'd0, awvalid}, 32'd0);
        checkOutput("t3_bready", {31'd0, bready}, 32'd1);
        checkOutput("t3_ok_before_b", {31'd0, data_data_ok}, 32'd0);
        stepCycle();
        checkOutput("t3_ok_still_waiting", {31'd0, data_data_ok}, 32'd0);
        bvalid = 1'b1;
        stepCycle();
        bvalid = 1'b0;
        checkOutput("t3_data_data_ok", {31'd0, data_data_ok}, 32'd1);
        checkOutput("t3_bready_low", {31'd0, bready}, 32'd0);
        stepCycle();
        checkOutput("t3_data_data_ok_once", {31'd0, data_data_ok}, 32'd0);

        // 4: reset asserted while waiting in RD_DATA
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0008;
        arready   = 1'b1;
        rvalid    = 1'b0;
        #1;
        checkOutput("t4_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        stepCycle();
        inst_req = 1'b0;
        stepCycle();
        checkOutput("t4_rready_before", {31'd0, rready}, 32'd1);
        resetn = 1'b0;
        #1;
        checkOutput("t4_rready_reset", {31'd0, rready}, 32'd0);
        checkOutput("t4_arvalid_reset", {31'd0, arvalid}, 32'd0);
        rvalid = 1'b1;
        rdata  = 32'hDEAD_BEEF;
        stepCycle();
        resetn = 1'b1;
        checkOutput("t4_no_data_ok_a", {31'd0, inst_data_ok}, 32'd0);
        stepCycle();
        checkOutput("t4_no_data_ok_b", {31'd0, inst_data_ok}, 32'd0);
        checkOutput("t4_inst_rdata_cleared", inst_rdata, 32'd0);
        data_req  = 1'b1;
        data_wr   = 1'b0;
        data_size = 2'd0;
        data_addr = 32'h8000_3003;
        rdata     = 32'h0000_00AB;
        #1;
        checkOutput("t4_next_addr_ok", {31'd0, data_addr_ok}, 32'd1);
        stepCycle();
        data_req = 1'b0;
        checkOutput("t4_byte_arsize", {29'd0, arsize}, 32'd0);
        checkOutput("t4_byte_araddr", araddr, 32'h8000_3003);
        stepCycle();
        stepCycle();
        checkOutput("t4_next_data_ok", {31'd0, data_data_ok}, 32'd1);
        checkOutput("t4_next_rdata", data_rdata, 32'h0000_00AB);
        checkOutput("t4_inst_quiet", {31'd0, inst_data_ok}, 32'd0);
        stepCycle();

        // 6: back-to-back data reads
        b2bAddr[0] = 32'h8000_4000; b2bData[0] = 32'hA5A5_0001;
        b2bAddr[1] = 32'h8000_4004; b2bData[1] = 32'h5A5A_0002;
        b2bAddr[2] = 32'h8000_4008; b2bData[2] = 32'hFFFF_0003;
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("t6_rd%0d", i), b2bAddr[i], b2bData[i]);
        end

`ifdef BRIDGE_TIMEOUT_EN
        // 5: arready withheld until the timeout flag is raised
        arready   = 1'b0;
        rvalid    = 1'b0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0010;
        #1;
        checkOutput("t5_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
        for (int c = 1; c <= 8; c++) begin
            stepCycle();
            inst_req = 1'b0;
            checkOutput($sformatf("t5_err_low_c%0d", c), {31'd0, err}, 32'd0);
        end
        stepCycle();
        checkOutput("t5_err_set", {31'd0, err}, 32'd1);
        checkOutput("t5_still_waiting", {31'd0, arvalid}, 32'd1);
        arready = 1'b1;
        rvalid  = 1'b1;
        rdata   = 32'h0BAD_0BAD;
        stepCycle();
        stepCycle();
        checkOutput("t5_completes", {31'd0, inst_data_ok}, 32'd1);
        checkOutput("t5_err_sticky", {31'd0, err}, 32'd1);
`else
        checkOutput("err_tied_low", {31'd0, err}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
